// File: rtl/calc_core_if.sv
// Command/result bundle between the parser, the arithmetic stage and the
// result encoder. The parser side drives the command, the core answers.
interface calc_core_if;
    logic        start;
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        busy;
    logic        res_valid;
    logic [31:0] result;
    logic [15:0] rem;
    logic        err;

    modport master (
        output start, dtype, op, src1, src2,
        input  busy, res_valid, result, rem, err
    );

    modport slave (
        input  start, dtype, op, src1, src2,
        output busy, res_valid, result, rem, err
    );
endinterface

// File: rtl/calc_core.sv
// Arithmetic execution stage: single-cycle add/sub, 16-step shift-add
// multiply and 16-step restoring divide on operand magnitudes, followed by
// a sign fix-up cycle. Results are presented with a one-cycle strobe.
module calc_core (
    input  logic       clk,
    input  logic       n_rst,
    calc_core_if.slave bus
);

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MUL = 5'h04;
    localparam logic [4:0] OP_DIV = 5'h08;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t      r_state, w_next;

    // latched command
    logic        r_sgn;       // signed mode
    logic        r_sub;
    logic        r_is_div;
    logic        r_neg_res;   // operand signs differ (signed only)
    logic        r_neg_rem;   // dividend negative (signed only)
    logic [15:0] r_a, r_b;    // raw operands for add/sub
    logic [15:0] r_mb;        // |src2|: multiplicand or divisor
    logic [4:0]  r_cnt;
    // shared iteration register: mul {acc_hi, multiplier/product_lo},
    // div {partial remainder, dividend/quotient}
    logic [31:0] r_p;
    logic [31:0] r_res;
    logic [15:0] r_rem;
    logic        r_err;

    // output registers
    logic [31:0] r_result;
    logic [15:0] r_rem_o;
    logic        r_err_o;
    logic        r_valid;

    // command decode, only meaningful while IDLE
    logic        w_sgn, w_op_ok, w_bad;
    logic [15:0] w_ma, w_mb;

    assign w_sgn   = (bus.dtype != 4'h1);
    assign w_op_ok = (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                     (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign w_bad   = !w_op_ok || ((bus.op == OP_DIV) && (bus.src2 == 16'h0000));
    // 0x8000 negates to itself, which reads correctly as 32768 unsigned
    assign w_ma    = (w_sgn && bus.src1[15]) ? (~bus.src1 + 16'd1) : bus.src1;
    assign w_mb    = (w_sgn && bus.src2[15]) ? (~bus.src2 + 16'd1) : bus.src2;

    // add/sub on 17-bit extended operands
    logic [16:0] w_ea, w_eb, w_as;
    assign w_ea = {r_sgn & r_a[15], r_a};
    assign w_eb = {r_sgn & r_b[15], r_b};
    assign w_as = r_sub ? (w_ea - w_eb) : (w_ea + w_eb);

    // one multiply step: conditionally add multiplicand into the high half
    logic [16:0] w_macc;
    assign w_macc = {1'b0, r_p[31:16]} + (r_p[0] ? {1'b0, r_mb} : 17'd0);

    // one restoring divide step: shift in next dividend bit, trial subtract
    logic [16:0] w_dt, w_dd;
    logic        w_qb;
    assign w_dt = {r_p[31:16], r_p[15]};
    assign w_dd = w_dt - {1'b0, r_mb};
    assign w_qb = (w_dt >= {1'b0, r_mb});

    // fix-up operands
    logic [31:0] w_q32, w_q32n, w_pn;
    logic [15:0] w_remn;
    assign w_q32  = {16'h0000, r_p[15:0]};
    assign w_q32n = ~w_q32 + 32'd1;
    assign w_pn   = ~r_p + 32'd1;
    assign w_remn = ~r_p[31:16] + 16'd1;

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state logic; errors travel through ADDSUB so every short
    // command has the same two-cycle latency
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_bad)                  w_next = S_ADDSUB;
                    else if (bus.op == OP_MUL)  w_next = S_MUL;
                    else if (bus.op == OP_DIV)  w_next = S_DIV;
                    else                        w_next = S_ADDSUB;
                end
            end
            S_ADDSUB: w_next = S_DONE;
            S_MUL:    if (r_cnt == 5'd1) w_next = S_FIX;
            S_DIV:    if (r_cnt == 5'd1) w_next = S_FIX;
            S_FIX:    w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        bus.busy = (r_state != S_IDLE);
    end

    // datapath: command latch, iterations and sign fix-up
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sgn     <= 1'b0;
            r_sub     <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_mb      <= '0;
            r_cnt     <= '0;
            r_p       <= '0;
            r_res     <= '0;
            r_rem     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sgn     <= w_sgn;
                        r_sub     <= (bus.op == OP_SUB);
                        r_is_div  <= (bus.op == OP_DIV);
                        r_neg_res <= w_sgn & (bus.src1[15] ^ bus.src2[15]);
                        r_neg_rem <= w_sgn & bus.src1[15];
                        r_a       <= bus.src1;
                        r_b       <= bus.src2;
                        r_mb      <= w_mb;
                        r_cnt     <= 5'd16;
                        r_p       <= {16'h0000, w_ma};
                        r_err     <= w_bad;
                    end
                end
                S_ADDSUB: begin
                    r_res <= {{15{r_sgn & w_as[16]}}, w_as};
                    r_rem <= '0;
                end
                S_MUL: begin
                    r_p   <= {w_macc, r_p[15:1]};
                    r_cnt <= r_cnt - 5'd1;
                end
                S_DIV: begin
                    r_p   <= {(w_qb ? w_dd[15:0] : w_dt[15:0]), r_p[14:0], w_qb};
                    r_cnt <= r_cnt - 5'd1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_res <= r_neg_res ? w_q32n : w_q32;
                        r_rem <= r_neg_rem ? w_remn : r_p[31:16];
                    end else begin
                        r_res <= r_neg_res ? w_pn : r_p;
                        r_rem <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // result registers: loaded only when leaving DONE, held otherwise
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_result <= '0;
            r_rem_o  <= '0;
            r_err_o  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_result <= r_err ? 32'h0 : r_res;
                r_rem_o  <= r_err ? 16'h0 : r_rem;
                r_err_o  <= r_err;
            end
        end
    end

    assign bus.res_valid = r_valid;
    assign bus.result    = r_result;
    assign bus.rem       = r_rem_o;
    assign bus.err       = r_err_o;

endmodule
